// File: rtl/ps2_mouse_pkg.sv
// PS/2 mouse command/response bytes, init-sequencer state encoding and state helpers.
// MOUSE_SAMPLE_RATE_EN adds the set-sample-rate states to the sequence.
package ps2_mouse_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_RST,
        ST_WAIT_ACK_RST,
        ST_WAIT_BAT,
        ST_WAIT_ID,
`ifdef MOUSE_SAMPLE_RATE_EN
        ST_SEND_SR,
        ST_WAIT_ACK_SR,
        ST_SEND_RATE,
        ST_WAIT_ACK_RATE,
`endif
        ST_SEND_EN,
        ST_WAIT_ACK_EN,
        ST_STREAM,
        ST_FAIL
    } state_e;

    function automatic logic is_send(state_e s);
`ifdef MOUSE_SAMPLE_RATE_EN
        return s inside {ST_SEND_RST, ST_SEND_SR, ST_SEND_RATE, ST_SEND_EN};
`else
        return s inside {ST_SEND_RST, ST_SEND_EN};
`endif
    endfunction

    function automatic logic is_ack(state_e s);
`ifdef MOUSE_SAMPLE_RATE_EN
        return s inside {ST_WAIT_ACK_RST, ST_WAIT_ACK_SR, ST_WAIT_ACK_RATE, ST_WAIT_ACK_EN};
`else
        return s inside {ST_WAIT_ACK_RST, ST_WAIT_ACK_EN};
`endif
    endfunction

    function automatic logic is_wait(state_e s);
        return is_ack(s) || s == ST_WAIT_BAT || s == ST_WAIT_ID;
    endfunction

    function automatic logic [7:0] expect_of(state_e s);
        case (s)
            ST_WAIT_BAT: return RSP_BAT_OK;
            ST_WAIT_ID:  return RSP_ID;
            default:     return RSP_ACK;
        endcase
    endfunction

    // Successor on a completed send or an expected response.
    function automatic state_e succ(state_e s);
        case (s)
            ST_SEND_RST:      return ST_WAIT_ACK_RST;
            ST_WAIT_ACK_RST:  return ST_WAIT_BAT;
            ST_WAIT_BAT:      return ST_WAIT_ID;
`ifdef MOUSE_SAMPLE_RATE_EN
            ST_WAIT_ID:       return ST_SEND_SR;
            ST_SEND_SR:       return ST_WAIT_ACK_SR;
            ST_WAIT_ACK_SR:   return ST_SEND_RATE;
            ST_SEND_RATE:     return ST_WAIT_ACK_RATE;
            ST_WAIT_ACK_RATE: return ST_SEND_EN;
`else
            ST_WAIT_ID:       return ST_SEND_EN;
`endif
            ST_SEND_EN:       return ST_WAIT_ACK_EN;
            ST_WAIT_ACK_EN:   return ST_STREAM;
            default:          return s;
        endcase
    endfunction

    function automatic state_e resend_of(state_e s);
        case (s)
`ifdef MOUSE_SAMPLE_RATE_EN
            ST_WAIT_ACK_SR:   return ST_SEND_SR;
            ST_WAIT_ACK_RATE: return ST_SEND_RATE;
`endif
            ST_WAIT_ACK_EN:   return ST_SEND_EN;
            default:          return ST_SEND_RST;
        endcase
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Per-state wait timer: clears on state entry, counts while enabled, saturates,
// and flags the last allowed cycle.
module ps2_timeout_timer #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);
    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cnt_q <= '0;
        else if (clr_i)              cnt_q <= '0;
        else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign timeout_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse init sequencer: reset, BAT/ID check, enable reporting, with retry/timeout.
// Define MOUSE_SAMPLE_RATE_EN to also program the sample rate before enabling.
module ps2_mouse_init_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int MAX_RETRY   = 3
`ifdef MOUSE_SAMPLE_RATE_EN
    , parameter logic [7:0] SAMPLE_RATE = 8'd100
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       stream_en,
    output logic       init_fail,
    output logic [1:0] retry_cnt
);
    state_e     state_q, state_d;
    logic [7:0] tx_data_q;
    logic       tx_req_q, stream_en_q, init_fail_q;
    logic [1:0] retry_q, fe_cnt_q;
    logic       evt, err, acc, fe, tmo, tmr_en;

    function automatic logic [7:0] cmd_of(state_e s);
        case (s)
`ifdef MOUSE_SAMPLE_RATE_EN
            ST_SEND_SR:   return CMD_SET_RATE;
            ST_SEND_RATE: return SAMPLE_RATE;
`endif
            ST_SEND_EN:   return CMD_ENABLE;
            default:      return CMD_RESET;
        endcase
    endfunction

    assign tmr_en = is_send(state_q) || is_wait(state_q);

    ps2_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (evt),
        .en_i     (tmr_en),
        .timeout_o(tmo)
    );

    // evt marks any state entry (including re-entry of the same state) so the timer clears.
    always_comb begin
        state_d = state_q;
        evt = 1'b0;
        err = 1'b0;
        acc = 1'b0;
        fe  = 1'b0;
        if (restart) begin
            state_d = ST_IDLE;
            evt = 1'b1;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_SEND_RST;
            evt = 1'b1;
        end else if (is_send(state_q)) begin
            if (tx_done) begin
                state_d = succ(state_q);
                evt = 1'b1;
            end else if (tx_err || tmo) begin
                err = 1'b1;
            end
        end else if (is_wait(state_q)) begin
            if (rx_valid) begin
                if (rx_data == expect_of(state_q)) begin
                    state_d = succ(state_q);
                    evt = 1'b1;
                    acc = 1'b1;
                end else if (rx_data == RSP_RESEND && is_ack(state_q) && fe_cnt_q != 2'd2) begin
                    state_d = resend_of(state_q);
                    evt = 1'b1;
                    fe  = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end else if (tmo) begin
                err = 1'b1;
            end
        end
        if (err) begin
            evt = 1'b1;
            state_d = (int'(retry_q) < MAX_RETRY) ? ST_SEND_RST : ST_FAIL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= 8'h00;
            tx_req_q    <= 1'b0;
            stream_en_q <= 1'b0;
            init_fail_q <= 1'b0;
            retry_q     <= 2'd0;
            fe_cnt_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            tx_req_q    <= evt && is_send(state_d);
            if (evt && is_send(state_d))
                tx_data_q <= cmd_of(state_d);
            stream_en_q <= (state_d == ST_STREAM);
            init_fail_q <= (state_d == ST_FAIL);
            if (restart)
                retry_q <= 2'd0;
            else if (err && int'(retry_q) < MAX_RETRY)
                retry_q <= retry_q + 2'd1;
            if (restart || err || acc)
                fe_cnt_q <= 2'd0;
            else if (fe)
                fe_cnt_q <= fe_cnt_q + 2'd1;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_req    = tx_req_q;
    assign stream_en = stream_en_q;
    assign init_fail = init_fail_q;
    assign retry_cnt = retry_q;

endmodule
